// File: rtl/sym_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sym_serializer
// Function : parallel code word to SYM_W-bit symbol stream, LSB symbol first,
//            with a one-word prefetch buffer for bubble-free streaming.
// Revision : 1.0
// ============================================================================
module sym_serializer #(
   parameter int SYM_W = 2,
   parameter int NSYM  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SYM_W*NSYM-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [SYM_W-1:0]      sym_out,
   output logic                  sym_valid,
   input  logic                  sym_ready,
   output logic                  word_start,
   output logic                  word_last,
   output logic                  underrun,
   input  logic                  clr_underrun
);

   localparam int c_WORD_W = SYM_W * NSYM;
   localparam int c_IDX_W  = $clog2(NSYM);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NSYM - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_WORD_W-1:0]   r_act;
   logic [c_WORD_W-1:0]   r_hold;
   logic [c_IDX_W-1:0]    r_idx;
   logic                  r_hold_full;
   logic                  r_armed;
   logic                  r_underrun;

   logic                  w_accept;

   assign w_accept = in_valid && !r_hold_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_act       <= '0;
         r_hold      <= '0;
         r_idx       <= '0;
         r_hold_full <= 1'b0;
         r_armed     <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         // The set below is written later so it wins over a same-cycle clear.
         if (clr_underrun)
            r_underrun <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_act   <= in_data;
                  r_idx   <= '0;
                  r_state <= ST_SHIFT;
                  r_armed <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (sym_ready && (r_idx == c_IDX_LAST)) begin
                  if (r_hold_full) begin
                     r_act       <= r_hold;
                     r_idx       <= '0;
                     r_hold_full <= 1'b0;
                  end else if (w_accept) begin
                     r_act <= in_data;
                     r_idx <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     if (r_armed)
                        r_underrun <= 1'b1;
                  end
               end else begin
                  if (sym_ready) begin
                     r_act <= r_act >> SYM_W;
                     r_idx <= r_idx + c_IDX_W'(1);
                  end
                  if (w_accept) begin
                     r_hold      <= in_data;
                     r_hold_full <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = !r_hold_full;
   assign sym_valid  = (r_state == ST_SHIFT);
   assign sym_out    = r_act[SYM_W-1:0];
   assign word_start = sym_valid && (r_idx == '0);
   assign word_last  = sym_valid && (r_idx == c_IDX_LAST);
   assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sym_serializer.sv
`default_nettype none
// Testbench for sym_serializer: directed scenarios, each checking a queue of
// expected symbols (with start/last flags) pushed when the word is driven.
module tb_sym_serializer;

   localparam int SYM_W = 2;
   localparam int NSYM  = 8;
   localparam int WW    = SYM_W * NSYM;

   typedef struct packed {
      logic [SYM_W-1:0] sym;
      logic             st;
      logic             ls;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic             clk          = 1'b0;
   logic             rst          = 1'b0;
   logic [WW-1:0]    in_data      = '0;
   logic             in_valid     = 1'b0;
   logic             in_ready;
   logic [SYM_W-1:0] sym_out;
   logic             sym_valid;
   logic             sym_ready    = 1'b0;
   logic             word_start;
   logic             word_last;
   logic             underrun;
   logic             clr_underrun = 1'b0;

   always #5 clk = ~clk;

   sym_serializer #(.SYM_W(SYM_W), .NSYM(NSYM)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sym_out      (sym_out),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .word_start   (word_start),
      .word_last    (word_last),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   function automatic void push_word(input logic [WW-1:0] w);
      exp_t e;
      for (int k = 0; k < NSYM; k++) begin
         e.sym = w[SYM_W*k +: SYM_W];
         e.st  = (k == 0);
         e.ls  = (k == NSYM - 1);
         exp_q.push_back(e);
      end
   endfunction

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({sym_valid, sym_out, word_start, word_last, underrun, in_ready} !== 7'b0000001) begin
         n_err++;
         $display("FAIL reset_init: outs v/s/ws/wl/u/rdy=%b required 0000001",
                  {sym_valid, sym_out, word_start, word_last, underrun, in_ready});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      in_data = 16'hB4E1; in_valid = 1'b1; sym_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({sym_valid, sym_out, word_start, word_last, underrun, in_ready} !== 7'b0000001) begin
         n_err++;
         $display("FAIL reset_async: outs v/s/ws/wl/u/rdy=%b required 0000001",
                  {sym_valid, sym_out, word_start, word_last, underrun, in_ready});
      end
      #1 rst = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_quiet: cycle %0d valid=%b rdy=%b underrun=%b required 0 1 0",
                     j, sym_valid, in_ready, underrun);
         end
      end
   endtask

   task automatic test_single();
      exp_t e;
      @(posedge clk); #1;
      in_data = 16'hB4E1; in_valid = 1'b1; sym_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || sym_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_pre: rdy=%b valid=%b required 1 0", in_ready, sym_valid);
      end
      push_word(16'hB4E1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '1;
      for (int j = 0; j < NSYM; j++) begin
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_valid: cycle %0d valid=%b required 1", j, sym_valid);
         end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL single_sym: cycle %0d got symbol %0d, none expected", j, sym_out);
         end else begin
            e = exp_q.pop_front();
            if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
               n_err++;
               $display("FAIL single_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                        j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (sym_valid !== 1'b0 || underrun !== 1'b1 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL single_end: valid=%b underrun=%b left=%0d required 0 1 0",
                  sym_valid, underrun, exp_q.size());
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      clr_underrun = 1'b0;
      n_cmp++;
      if (underrun !== 1'b0) begin
         n_err++;
         $display("FAIL single_clr: underrun=%b required 0", underrun);
      end
   endtask

   task automatic test_stream();
      exp_t e;
      @(posedge clk); #1;
      in_data = 16'h0000; in_valid = 1'b1; sym_ready = 1'b1;
      push_word(16'h0000);
      @(posedge clk); #1;
      in_data = 16'hFFFF;
      for (int j = 1; j <= 17; j++) begin
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== (j <= 16) || in_ready !== !(j >= 2 && j <= 8) ||
             underrun !== (j == 17)) begin
            n_err++;
            $display("FAIL stream_flags: cycle %0d valid/rdy/underrun=%b%b%b required %b%b%b",
                     j, sym_valid, in_ready, underrun, (j <= 16), !(j >= 2 && j <= 8), (j == 17));
         end
         if (sym_valid && sym_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stream_sym: cycle %0d got symbol %0d, none expected", j, sym_out);
            end else begin
               e = exp_q.pop_front();
               if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
                  n_err++;
                  $display("FAIL stream_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                           j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
               end
            end
         end
         if (j == 1) begin
            push_word(16'hFFFF);
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_drain: %0d symbols left required 0", exp_q.size());
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      clr_underrun = 1'b0;
   endtask

   task automatic test_stall();
      exp_t e;
      int   consumed = 0;
      int   stalls   = 0;
      int   held3    = 0;
      @(posedge clk); #1;
      in_data = 16'hE4E4; in_valid = 1'b1; sym_ready = 1'b1;
      push_word(16'hE4E4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 20 && consumed < NSYM; c++) begin
         sym_ready = !(consumed == 3 && stalls < 3);
         if (!sym_ready) stalls++;
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_valid: cycle %0d valid=%b required 1", c, sym_valid);
         end
         if (sym_valid && consumed == 3 && sym_out == 2'd3) held3++;
         if (sym_valid && !sym_ready) begin
            n_cmp++;
            if (exp_q.size() == 0 || sym_out !== exp_q[0].sym) begin
               n_err++;
               $display("FAIL stall_hold: cycle %0d sym=%0d required 3", c, sym_out);
            end
         end
         if (sym_valid && sym_ready) begin
            n_cmp++;
            consumed++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stall_sym: cycle %0d got symbol %0d, none expected", c, sym_out);
            end else begin
               e = exp_q.pop_front();
               if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
                  n_err++;
                  $display("FAIL stall_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                           c, sym_out, word_start, word_last, e.sym, e.st, e.ls);
               end
            end
         end
         @(posedge clk); #1;
      end
      sym_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (consumed != NSYM || held3 != 4 || sym_valid !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stall_end: consumed=%0d held3=%0d valid=%b left=%0d required 8 4 0 0",
                  consumed, held3, sym_valid, exp_q.size());
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      clr_underrun = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      exp_t e;
      @(posedge clk); #1;
      in_data = 16'h1B1B; in_valid = 1'b1; sym_ready = 1'b1;
      push_word(16'h1B1B);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         n_cmp++;
         if (!sym_valid || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rmid_pre: cycle %0d valid=%b required 1", j, sym_valid);
         end else begin
            e = exp_q.pop_front();
            if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
               n_err++;
               $display("FAIL rmid_pre: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                        j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
            end
         end
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      exp_q.delete();
      n_cmp++;
      if ({sym_valid, sym_out, word_start, word_last, underrun, in_ready} !== 7'b0000001) begin
         n_err++;
         $display("FAIL rmid_reset: outs v/s/ws/wl/u/rdy=%b required 0000001",
                  {sym_valid, sym_out, word_start, word_last, underrun, in_ready});
      end
      #1 rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_quiet: cycle %0d valid=%b required 0", j, sym_valid);
         end
      end
      @(posedge clk); #1;
      in_data = 16'h5555; in_valid = 1'b1;
      push_word(16'h5555);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j <= NSYM; j++) begin
         @(negedge clk);
         n_cmp++;
         if (sym_valid !== (j < NSYM)) begin
            n_err++;
            $display("FAIL rmid_valid: cycle %0d valid=%b required %b", j, sym_valid, (j < NSYM));
         end else if (sym_valid) begin
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rmid_sym: cycle %0d got symbol %0d, none expected", j, sym_out);
            end else begin
               e = exp_q.pop_front();
               if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
                  n_err++;
                  $display("FAIL rmid_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                           j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
               end
            end
         end
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      clr_underrun = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      @(posedge clk); #1;
      in_data = 16'h1234; in_valid = 1'b1; sym_ready = 1'b1;
      push_word(16'h1234);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j <= 2*NSYM; j++) begin
         @(negedge clk);
         if (j == NSYM) in_valid = 1'b0;
         n_cmp++;
         if (sym_valid !== (j < 2*NSYM) || underrun !== (j == 2*NSYM)) begin
            n_err++;
            $display("FAIL b2b_flags: cycle %0d valid/underrun=%b%b required %b%b",
                     j, sym_valid, underrun, (j < 2*NSYM), (j == 2*NSYM));
         end
         if (sym_valid && sym_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL b2b_sym: cycle %0d got symbol %0d, none expected", j, sym_out);
            end else begin
               e = exp_q.pop_front();
               if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
                  n_err++;
                  $display("FAIL b2b_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                           j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
               end
            end
         end
         // Offer the second word exactly as the last symbol of the first is taken.
         if (j == NSYM - 1) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_ready: rdy=%b required 1", in_ready);
            end
            in_data = 16'hC3A5; in_valid = 1'b1;
            push_word(16'hC3A5);
         end
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      clr_underrun = 1'b0;
   endtask

   task automatic test_clr_priority();
      exp_t e;
      @(posedge clk); #1;
      in_data = 16'h3C5A; in_valid = 1'b1; sym_ready = 1'b1;
      push_word(16'h3C5A);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 0; j < NSYM; j++) begin
         @(negedge clk);
         n_cmp++;
         if (!sym_valid || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL clr_sym: cycle %0d valid=%b required 1", j, sym_valid);
         end else begin
            e = exp_q.pop_front();
            if ({sym_out, word_start, word_last} !== {e.sym, e.st, e.ls}) begin
               n_err++;
               $display("FAIL clr_sym: cycle %0d sym/ws/wl=%0d/%b/%b required %0d/%b/%b",
                        j, sym_out, word_start, word_last, e.sym, e.st, e.ls);
            end
         end
      end
      n_cmp++;
      if (underrun !== 1'b0) begin
         n_err++;
         $display("FAIL clr_before: underrun=%b required 0", underrun);
      end
      clr_underrun = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (underrun !== 1'b1) begin
         n_err++;
         $display("FAIL clr_same_cycle: underrun=%b required 1", underrun);
      end
      @(posedge clk); #1;
      clr_underrun = 1'b0;
      n_cmp++;
      if (underrun !== 1'b0) begin
         n_err++;
         $display("FAIL clr_next_cycle: underrun=%b required 0", underrun);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_stall();
      test_reset_mid_word();
      test_back_to_back();
      test_clr_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
